// File: rtl/sign_bcd_pkg.sv
// Shared widths and types for the signed binary to sign-magnitude BCD path.
package sign_bcd_pkg;

  localparam int BIN_W      = 8;
  localparam int BCD_DIGITS = 3;
  localparam int BCD_W      = BCD_DIGITS * 4;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_double_dabble.sv
// Combinational 8-bit unsigned to three-digit BCD converter (shift-and-add-3).
module bcd_double_dabble
  import sign_bcd_pkg::*;
(
  input  logic [BIN_W-1:0] mag,
  output bcd_digit_t       hundreds,
  output bcd_digit_t       tens,
  output bcd_digit_t       ones
);

  // BCD digits live above the binary bits; the whole vector shifts left once per stage.
  logic [BCD_W+BIN_W-1:0] scratch;

  // Unrolled double dabble: adjust every nibble >= 5 by +3, then shift, for all 8 bits.
  always_comb begin
    scratch = '0;
    scratch[BIN_W-1:0] = mag;
    for (int i = 0; i < BIN_W; i++) begin
      for (int d = 0; d < BCD_DIGITS; d++) begin
        if (scratch[BIN_W+4*d +: 4] >= 4'd5) begin
          scratch[BIN_W+4*d +: 4] = scratch[BIN_W+4*d +: 4] + 4'd3;
        end
      end
      scratch = scratch << 1;
    end
  end

  assign ones     = scratch[BIN_W +: 4];
  assign tens     = scratch[BIN_W+4 +: 4];
  assign hundreds = scratch[BIN_W+8 +: 4];

endmodule

// File: rtl/sign_bcd_converter.sv
// Registered two's-complement to sign-magnitude BCD converter, one-cycle latency.
module sign_bcd_converter
  import sign_bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] binary,
  output logic             sign_b,
  output bcd_digit_t       hundreds,
  output bcd_digit_t       tens,
  output bcd_digit_t       ones
);

  logic [BIN_W-1:0] mag;
  bcd_digit_t       hundreds_c;
  bcd_digit_t       tens_c;
  bcd_digit_t       ones_c;

  // Magnitude as an unsigned byte; -128 negates to 8'h80 which reads as 128.
  always_comb begin
    mag = binary;
    if (binary[BIN_W-1]) begin
      mag = (~binary) + 8'd1;
    end
  end

  bcd_double_dabble u_dabble (
    .mag      (mag),
    .hundreds (hundreds_c),
    .tens     (tens_c),
    .ones     (ones_c)
  );

  // Output bank: sign and all digits captured together so they stay coherent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_b   <= 1'b0;
      hundreds <= '0;
      tens     <= '0;
      ones     <= '0;
    end else begin
      sign_b   <= binary[BIN_W-1];
      hundreds <= hundreds_c;
      tens     <= tens_c;
      ones     <= ones_c;
    end
  end

endmodule

// File: tb/tb_sign_bcd_converter.sv
// Bench for sign_bcd_converter: directed corners, exhaustive sweep, random, resets.
module tb_sign_bcd_converter;

  logic       clk;
  logic       rst_n;
  logic [7:0] binary;
  logic       sign_b;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;

  int errors = 0;
  int checks = 0;

  sign_bcd_converter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .binary   (binary),
    .sign_b   (sign_b),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: signed value, absolute value, decimal digits by plain arithmetic.
  function automatic logic [12:0] ref_model(input logic [7:0] b);
    int v;
    int m;
    logic s;
    logic [3:0] h, t, o;
    v = int'($signed(b));
    s = (v < 0);
    m = (v < 0) ? -v : v;
    h = 4'(m / 100);
    t = 4'((m / 10) % 10);
    o = 4'(m % 10);
    return {s, h, t, o};
  endfunction

  function automatic logic [12:0] observed();
    return {sign_b, hundreds, tens, ones};
  endfunction

  task automatic check(input string tag, input logic [12:0] exp);
    logic [12:0] obs;
    obs = observed();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got sign=%b %0d/%0d/%0d want sign=%b %0d/%0d/%0d",
             tag, obs[12], obs[11:8], obs[7:4], obs[3:0],
             exp[12], exp[11:8], exp[7:4], exp[3:0]);
    end
  endtask

  // Drive at negedge, sample 1 time unit after the capturing posedge.
  task automatic apply(input logic [7:0] b);
    @(negedge clk);
    binary = b;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_check(input string tag, input logic [7:0] b, input logic [12:0] exp);
    apply(b);
    check(tag, exp);
  endtask

  initial begin
    // Reset held with a negative input: outputs must be zero.
    rst_n  = 1'b0;
    binary = 8'hFF;
    #1;
    check("reset_immediate", 13'h0);
    @(posedge clk);
    #1;
    check("reset_held_edge", 13'h0);

    // Release between edges; first edge with rst_n high captures -1.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release_first", {1'b1, 4'd0, 4'd0, 4'd1});

    // Directed corners with hand-written expectations.
    apply_check("pos_zero",   8'd0,   {1'b0, 4'd0, 4'd0, 4'd0});
    apply_check("pos_127",    8'd127, {1'b0, 4'd1, 4'd2, 4'd7});
    apply_check("pos_100",    8'd100, {1'b0, 4'd1, 4'd0, 4'd0});
    apply_check("pos_99",     8'd99,  {1'b0, 4'd0, 4'd9, 4'd9});
    apply_check("neg_128",    8'h80,  {1'b1, 4'd1, 4'd2, 4'd8});
    apply_check("neg_1",      8'hFF,  {1'b1, 4'd0, 4'd0, 4'd1});
    apply_check("neg_100",    8'h9C,  {1'b1, 4'd1, 4'd0, 4'd0});

    // Hold: stable input keeps the same result on the next edge.
    @(posedge clk);
    #1;
    check("hold_stable", {1'b1, 4'd1, 4'd0, 4'd0});

    // Back-to-back sequence, one result per cycle.
    apply_check("b2b_127",  8'd127, {1'b0, 4'd1, 4'd2, 4'd7});
    apply_check("b2b_m128", 8'h80,  {1'b1, 4'd1, 4'd2, 4'd8});
    apply_check("b2b_zero", 8'h00,  {1'b0, 4'd0, 4'd0, 4'd0});
    apply_check("b2b_m1",   8'hFF,  {1'b1, 4'd0, 4'd0, 4'd1});

    // Output must not change before the capturing edge (exactly one cycle latency).
    @(negedge clk);
    binary = 8'd42;
    #1;
    check("latency_pre_edge", {1'b1, 4'd0, 4'd0, 4'd1});
    @(posedge clk);
    #1;
    check("latency_post_edge", ref_model(8'd42));

    // Exhaustive sweep with a mid-stream reset pulse.
    for (int code = 0; code < 256; code++) begin
      apply_check("sweep", 8'(code), ref_model(8'(code)));
      if (code == 150) begin
        // Pulse low between edges: outputs clear at once and stay clear until next edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_async", 13'h0);
        rst_n = 1'b1;
        #1;
        check("midreset_released", 13'h0);
      end
      if (code == 200) begin
        // Reset across an edge: in-flight sample discarded.
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        binary = 8'd77;
        @(posedge clk);
        #1;
        check("midreset_across_edge", 13'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_resume", ref_model(8'd77));
      end
    end

    // Randomized stimulus against the reference.
    for (int n = 0; n < 300; n++) begin
      logic [7:0] r;
      r = 8'($urandom_range(0, 255));
      apply_check("random", r, ref_model(r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
